motor_speed_fsm: RTL and testbench
==================================

Name: motor_speed_fsm

Overview:
Control stage that sits directly upstream of the LED bar driver. It conditions three raw push-buttons and runs the 5-level motor speed state machine, with an optional auto-off countdown timer. It emits the 3-bit speed state consumed by the LED bar driver, plus an 8-bit duty code consumed by the downstream PWM generator.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, clocks a synchronised input must stay stable before its debounced level updates (10 ms at 100 MHz)
TICK_CYCLES, 100_000_000, clocks per 1-second timer tick
TIMER_S1, 3, seconds loaded for timer preset 1 (range 1..15)
TIMER_S2, 5, seconds loaded for timer preset 2 (range 1..15)
TIMER_S3, 7, seconds loaded for timer preset 3 (range 1..15)

Ports:
i_clk  input  1  system clock; single clock domain
i_reset  input  1  synchronous, active-high reset
i_btn_speed  input  1  raw button, asynchronous; each press advances speed
i_btn_off  input  1  raw button, asynchronous; forces motor off
i_btn_timer  input  1  raw button, asynchronous; cycles the timer preset
o_led_state  output  3  speed state 0..4 (000=OFF, 001..100=levels 1..4); feeds the LED bar driver
o_duty  output  8  PWM duty code for the current state
o_timer_sel  output  2  active timer preset (0 = none)
o_time_left  output  4  seconds remaining on the countdown

Behaviour:
- Reset (i_reset=1 sampled on a rising i_clk edge):
  - state=OFF, o_led_state=0, o_duty=0, o_timer_sel=0, o_time_left=0.
  - Prescaler, sync flops, debounce counters and debounced levels all clear to 0.
  - Reset mid-countdown abandons the countdown; no expiry event is produced.
- Button conditioning, applied per button:
  - 2-FF synchroniser.
  - Debounce counter: counts while the synchronised value differs from the debounced level, and clears on any match. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value.
  - A rising edge of the debounced level produces a 1-cycle pulse. Releases produce no pulse.
  - Holding a button produces exactly one pulse.
- Speed FSM states: S_OFF=0, S_1=1, S_2=2, S_3=3, S_4=4 (3'b101..3'b111 unreachable; if ever entered, go to S_OFF).
  - speed pulse: OFF->S_1->S_2->S_3->S_4->S_1. Wraps to S_1, never to OFF.
  - off pulse: any state -> S_OFF, timer_sel->0, time_left->0.
  - timer expiry: -> S_OFF, timer_sel->0.
  - Same-cycle priority: reset > off pulse > expiry > speed pulse. Lower-priority events in that cycle are dropped.
- Duty mapping, registered together with state: OFF=0, S_1=64, S_2=128, S_3=192, S_4=255.
- Latency: all outputs are registered. The state and duty change on the clock edge after the internal pulse. From a raw edge stable at the input, the output change takes 2 sync cycles + DEBOUNCE_CYCLES + 2 cycles.
- Timer:
  - timer pulse: sel cycles 0->1->2->3->0.
  - On each sel change, time_left loads the preset (0 for sel=0) and the prescaler clears.
  - A timer pulse arriving in the same cycle as an off pulse or an expiry is dropped.
  - Countdown runs only while sel!=0 and state!=OFF. Otherwise the prescaler and time_left hold.
  - When the prescaler reaches TICK_CYCLES-1 it wraps to 0 and issues a tick.
  - On a tick: if time_left>1, decrement. If time_left==1, time_left->0 and the expiry fires on that same edge.
  - Speed pulses do not reload or pause the timer.
  - A preset selected while state=OFF is held, and starts counting on the first speed pulse.
- All arithmetic is unsigned with no overflow. time_left never underflows below 0.

Decomposition:
- Shared package/header: state encodings S_OFF..S_4 (shared with the LED bar driver), duty constants per state, timer-select encodings.
- One sub-module: btn_conditioner (synchroniser + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.
- FSM, timer and prescaler stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, TICK_CYCLES=10, TIMER_S1=3):
- Debounce: after reset, pulse i_btn_speed high for 3 cycles with glitches, then low -> o_led_state stays 0. Hold high 20 cycles -> o_led_state=1, o_duty=64 exactly once, no further change while held.
- Speed wrap: 5 clean speed presses -> o_led_state goes 1,2,3,4,1 and o_duty goes 64,128,192,255,64.
- Timer expiry: state=2, one timer press -> o_timer_sel=1, o_time_left=3. It decrements every 10 cycles to 2, 1, and on the third tick o_led_state=0, o_duty=0, o_timer_sel=0, o_time_left=0.
- Off priority: off and speed debounced pulses aligned to the same cycle in state 3 -> o_led_state=0. Off during a countdown clears o_timer_sel and o_time_left to 0.
- Timer while OFF: timer press in OFF -> o_time_left=3 holds for 50 cycles. Then a speed press -> state=1 and the countdown starts.
- Reset mid-operation: assert i_reset for 1 cycle at state=4, time_left=2 -> all outputs 0 on the next edge, and no spurious pulse follows from a button still held (the debounced level restarts at 0, so exactly one press registers after debounce).

Source files
------------

// File: rtl/motor_speed_fsm_pkg.sv
// Shared encodings for the motor speed stage: speed states (also read by the LED bar
// driver), per-state PWM duty codes and timer preset selects.
package motor_speed_fsm_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned TSEL_W  = 2;
  localparam int unsigned TIME_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    S_OFF = 3'd0,
    S_1   = 3'd1,
    S_2   = 3'd2,
    S_3   = 3'd3,
    S_4   = 3'd4
  } speed_state_e;

  typedef enum logic [TSEL_W-1:0] {
    TSEL_NONE = 2'd0,
    TSEL_1    = 2'd1,
    TSEL_2    = 2'd2,
    TSEL_3    = 2'd3
  } timer_sel_e;

  localparam logic [DUTY_W-1:0] DUTY_OFF = 8'd0;
  localparam logic [DUTY_W-1:0] DUTY_1   = 8'd64;
  localparam logic [DUTY_W-1:0] DUTY_2   = 8'd128;
  localparam logic [DUTY_W-1:0] DUTY_3   = 8'd192;
  localparam logic [DUTY_W-1:0] DUTY_4   = 8'd255;

  function automatic logic [DUTY_W-1:0] duty_for(input speed_state_e s);
    case (s)
      S_1:     duty_for = DUTY_1;
      S_2:     duty_for = DUTY_2;
      S_3:     duty_for = DUTY_3;
      S_4:     duty_for = DUTY_4;
      default: duty_for = DUTY_OFF;
    endcase
  endfunction

  // Speed button order; S_4 wraps back to S_1, never to OFF.
  function automatic speed_state_e next_speed(input speed_state_e s);
    case (s)
      S_OFF:   next_speed = S_1;
      S_1:     next_speed = S_2;
      S_2:     next_speed = S_3;
      S_3:     next_speed = S_4;
      S_4:     next_speed = S_1;
      default: next_speed = S_OFF;
    endcase
  endfunction

  function automatic timer_sel_e next_tsel(input timer_sel_e s);
    case (s)
      TSEL_NONE: next_tsel = TSEL_1;
      TSEL_1:    next_tsel = TSEL_2;
      TSEL_2:    next_tsel = TSEL_3;
      default:   next_tsel = TSEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/motor_speed_fsm_btn_conditioner.sv
// Raw push-button conditioner: 2-FF synchroniser, stability debounce and a
// registered one-cycle pulse on each debounced press.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_ff1;
  logic             sync_ff2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Counter only survives while the synchronised input disagrees with the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
      level    <= 1'b0;
      level_d  <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync_ff1 <= btn_raw;
      sync_ff2 <= sync_ff1;
      if (sync_ff2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_ff2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/motor_speed_fsm.sv
// Motor speed control stage: conditions three buttons, runs the 5-level speed FSM
// and an optional auto-off countdown; feeds the LED bar driver and PWM generator.
module motor_speed_fsm
  import motor_speed_fsm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 100_000_000,
  parameter int unsigned TIMER_S1        = 3,
  parameter int unsigned TIMER_S2        = 5,
  parameter int unsigned TIMER_S3        = 7
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_btn_speed,
  input  logic              i_btn_off,
  input  logic              i_btn_timer,
  output logic [STATE_W-1:0] o_led_state,
  output logic [DUTY_W-1:0]  o_duty,
  output logic [TSEL_W-1:0]  o_timer_sel,
  output logic [TIME_W-1:0]  o_time_left
);

  localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  logic speed_p, off_p, timer_p;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_speed (
    .clk(i_clk), .reset(i_reset), .btn_raw(i_btn_speed), .pulse(speed_p)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_off (
    .clk(i_clk), .reset(i_reset), .btn_raw(i_btn_off), .pulse(off_p)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_timer (
    .clk(i_clk), .reset(i_reset), .btn_raw(i_btn_timer), .pulse(timer_p)
  );

  function automatic logic [TIME_W-1:0] preset_for(input timer_sel_e s);
    case (s)
      TSEL_1:  preset_for = TIME_W'(TIMER_S1);
      TSEL_2:  preset_for = TIME_W'(TIMER_S2);
      TSEL_3:  preset_for = TIME_W'(TIMER_S3);
      default: preset_for = '0;
    endcase
  endfunction

  speed_state_e      state_q, state_n;
  timer_sel_e        sel_q, sel_n;
  logic [DUTY_W-1:0] duty_q, duty_n;
  logic [TIME_W-1:0] tl_q, tl_n;
  logic [PRE_W-1:0]  pre_q, pre_n;
  logic              counting, tick, expire;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_OFF;
      sel_q   <= TSEL_NONE;
      duty_q  <= DUTY_OFF;
      tl_q    <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      duty_q  <= duty_n;
      tl_q    <= tl_n;
      pre_q   <= pre_n;
    end
  end

  // Priority: off pulse > expiry > speed/timer pulses.
  always_comb begin
    state_n  = (state_q > S_4) ? S_OFF : state_q;
    sel_n    = sel_q;
    tl_n     = tl_q;
    pre_n    = pre_q;
    expire   = 1'b0;
    counting = (sel_q != TSEL_NONE) && (state_q != S_OFF);
    tick     = counting && (pre_q == PRE_LAST);

    if (counting) begin
      pre_n = tick ? '0 : pre_q + PRE_W'(1);
      if (tick) begin
        if (tl_q > TIME_W'(1)) begin
          tl_n = tl_q - TIME_W'(1);
        end else if (tl_q == TIME_W'(1)) begin
          tl_n   = '0;
          expire = 1'b1;
        end
      end
    end

    if (off_p || expire) begin
      state_n = S_OFF;
      sel_n   = TSEL_NONE;
      tl_n    = '0;
      pre_n   = '0;
    end else begin
      if (speed_p) begin
        state_n = next_speed(state_q);
      end
      if (timer_p) begin
        sel_n = next_tsel(sel_q);
        tl_n  = preset_for(sel_n);
        pre_n = '0;
      end
    end

    duty_n = duty_for(state_n);
  end

  assign o_led_state = state_q;
  assign o_duty      = duty_q;
  assign o_timer_sel = sel_q;
  assign o_time_left = tl_q;

endmodule

// File: tb/tb_motor_speed_fsm.sv
// Directed bench for motor_speed_fsm with short debounce/tick periods: table of button
// presses plus hand-timed sequences for debounce, timer, priority and reset cases.
module tb_motor_speed_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_speed, btn_off, btn_timer;
  logic [2:0] led_state;
  logic [7:0] duty;
  logic [1:0] timer_sel;
  logic [3:0] time_left;

  motor_speed_fsm #(
    .DEBOUNCE_CYCLES(4), .TICK_CYCLES(10), .TIMER_S1(3), .TIMER_S2(5), .TIMER_S3(7)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_btn_speed(btn_speed), .i_btn_off(btn_off), .i_btn_timer(btn_timer),
    .o_led_state(led_state), .o_duty(duty), .o_timer_sel(timer_sel), .o_time_left(time_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int btn;    // 0 speed, 1 off
    int st;
    int dty;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_speed = v;
      1: btn_off   = v;
      default: btn_timer = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    cycles(12);
    set_btn(which, 1'b0);
    cycles(12);
  endtask

  function automatic int read_out(input int which);
    case (which)
      0: return int'(led_state);
      1: return int'(timer_sel);
      default: return int'(time_left);
    endcase
  endfunction

  // Bounded wait for an output (0 state, 1 sel, 2 time_left) to reach a value.
  task automatic wait_for(input int which, input int val, input int budget, input string name);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (n < budget && !hit) begin
      @(negedge clk);
      n++;
      if (read_out(which) == val) hit = 1'b1;
    end
    checks++;
    if (hit) passes++;
    else $display("FAIL %s: value %0d not reached in %0d cycles, now %0d", name, val, budget,
                  read_out(which));
  endtask

  // Counts how often the state output changes over n cycles.
  task automatic count_changes(input int n, output int trans);
    logic [2:0] prev;
    trans = 0;
    prev  = led_state;
    repeat (n) begin
      @(negedge clk);
      if (led_state != prev) trans++;
      prev = led_state;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int trans;
    reset = 1'b1; btn_speed = 1'b0; btn_off = 1'b0; btn_timer = 1'b0;
    cycles(3);
    reset = 1'b0;
    check("reset_state", led_state, 0);
    check("reset_duty", duty, 0);
    check("reset_sel", timer_sel, 0);
    check("reset_time", time_left, 0);

    // Glitchy burst never stays stable long enough.
    btn_speed = 1'b1; cycles(2);
    btn_speed = 1'b0; cycles(1);
    btn_speed = 1'b1; cycles(1);
    btn_speed = 1'b0; cycles(15);
    check("glitch_state", led_state, 0);
    check("glitch_duty", duty, 0);

    btn_speed = 1'b1;
    count_changes(20, trans);
    check("hold_changes", trans, 1);
    check("hold_state", led_state, 1);
    check("hold_duty", duty, 64);
    btn_speed = 1'b0;
    cycles(12);

    tbl[0] = '{1, 0, 0};
    tbl[1] = '{0, 1, 64};
    tbl[2] = '{0, 2, 128};
    tbl[3] = '{0, 3, 192};
    tbl[4] = '{0, 4, 255};
    tbl[5] = '{0, 1, 64};
    tbl[6] = '{0, 2, 128};
    for (int i = 0; i < 7; i++) begin
      press(tbl[i].btn);
      check($sformatf("tbl%0d_state", i), led_state, tbl[i].st);
      check($sformatf("tbl%0d_duty", i), duty, tbl[i].dty);
    end

    // Timer expiry from state 2.
    btn_timer = 1'b1;
    wait_for(1, 1, 20, "timer_sel_load");
    btn_timer = 1'b0;
    check("timer_load_time", time_left, 3);
    cycles(9);
    check("timer_pre_tick1", time_left, 3);
    cycles(1);
    check("timer_tick1", time_left, 2);
    cycles(10);
    check("timer_tick2", time_left, 1);
    cycles(9);
    check("timer_pre_expiry_state", led_state, 2);
    cycles(1);
    check("expiry_state", led_state, 0);
    check("expiry_duty", duty, 0);
    check("expiry_sel", timer_sel, 0);
    check("expiry_time", time_left, 0);

    // Off and speed pulses land in the same cycle in state 3.
    press(0); press(0); press(0);
    check("pre_prio_state", led_state, 3);
    btn_off = 1'b1; btn_speed = 1'b1;
    cycles(15);
    btn_off = 1'b0; btn_speed = 1'b0;
    cycles(12);
    check("prio_state", led_state, 0);
    check("prio_duty", duty, 0);

    // Off during a running countdown.
    press(0);
    press(2);
    check("cd_sel", timer_sel, 1);
    check("cd_state", led_state, 1);
    press(1);
    check("cd_off_state", led_state, 0);
    check("cd_off_sel", timer_sel, 0);
    check("cd_off_time", time_left, 0);

    // Preset chosen while OFF holds until the first speed press.
    press(2);
    check("off_tmr_sel", timer_sel, 1);
    cycles(50);
    check("off_tmr_hold", time_left, 3);
    check("off_tmr_state", led_state, 0);
    btn_speed = 1'b1;
    wait_for(0, 1, 20, "off_tmr_start");
    cycles(9);
    check("off_tmr_pre_tick", time_left, 3);
    cycles(1);
    check("off_tmr_tick", time_left, 2);
    btn_speed = 1'b0;

    // Reset at state 4 with time_left 2 while speed is held.
    press(1);
    press(0); press(0); press(0);
    btn_speed = 1'b1;
    wait_for(0, 4, 20, "rst_reach_s4");
    btn_timer = 1'b1;
    wait_for(1, 1, 20, "rst_sel_load");
    btn_timer = 1'b0;
    wait_for(2, 2, 15, "rst_reach_t2");
    check("rst_pre_state", led_state, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_state", led_state, 0);
    check("rst_duty", duty, 0);
    check("rst_sel", timer_sel, 0);
    check("rst_time", time_left, 0);
    count_changes(20, trans);
    check("rst_held_changes", trans, 1);
    check("rst_held_state", led_state, 1);
    check("rst_held_sel", timer_sel, 0);
    btn_speed = 1'b0;
    cycles(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
